wb_port_arbiter: RTL and testbench

Shares the single register-file write port of the filter processor between the pipeline writeback stream (the MEM/WB stage outputs) and an auxiliary requester, the filter accelerator result unit. Pipeline writes have priority. Auxiliary writes wait in a 2-entry buffer and are granted on idle writeback cycles. A wait counter forces a one-cycle pipeline stall so that auxiliary writes cannot starve. The block sits between MEM/WB and the register file. It also exports a pending-write mask that decode uses for hazard checks.

---
 rtl/wb_port_arbiter_pkg.sv | 24 ++
 rtl/aux_wb_fifo.sv | 54 +++++
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// FSM states, writeback payload, aux entry and sizing constants.
package wb_port_arbiter_pkg;

  localparam int REG_COUNT = 16;
  localparam int AUX_DEPTH = 2;

  typedef enum logic {
    PIPE  = 1'b0,
    DRAIN = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
    logic [3:0]  dir;
  } wb_pay_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  dir;
  } aux_ent_t;

endpackage

// File: rtl/aux_wb_fifo.sv
// Two-entry FIFO holding auxiliary register-file writes.
// Ports: push/pop strobes, new entry in, head out, count and per-slot taps.
module aux_wb_fifo
  import wb_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  aux_ent_t             push_ent,
  input  logic                 pop,
  output aux_ent_t             head,
  output logic [1:0]           count,
  output logic [AUX_DEPTH-1:0] ent_vld,
  output logic [3:0]           ent_dir [AUX_DEPTH]
);

  aux_ent_t   slot_q [AUX_DEPTH];
  logic [1:0] cnt_q;

  // Slot 0 is always the head; a pop shifts slot 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          slot_q[cnt_q[0]] <= push_ent;
          cnt_q            <= cnt_q + 2'd1;
        end
        2'b01: begin
          slot_q[0] <= slot_q[1];
          cnt_q     <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Push is only possible below two entries.
          slot_q[0] <= (cnt_q == 2'd1) ? push_ent
                                       : slot_q[1];
          slot_q[1] <= push_ent;
        end
        default: ;
      endcase
    end
  end

  assign head       = slot_q[0];
  assign count      = cnt_q;
  assign ent_vld[0] = (cnt_q != 2'd0);
  assign ent_vld[1] = (cnt_q == 2'd2);
  assign ent_dir[0] = slot_q[0].dir;
  assign ent_dir[1] = slot_q[1].dir;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port: pipeline first, aux on idle
// slots, forced one-cycle drain after MAX_WAIT lost cycles.
// Ports: MEM/WB write in, aux req/ready, RF write out, stall, mask, err.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_WE_MEM_WB,
  input  logic [31:0] i_WB_Data,
  input  logic [3:0]  i_WB_Dir,
  input  logic        i_aux_valid,
  input  logic [31:0] i_aux_data,
  input  logic [3:0]  i_aux_dir,
  output logic        o_aux_ready,
  output logic        o_RF_WE,
  output logic [31:0] o_RF_Data,
  output logic [3:0]  o_RF_Dir,
  output logic        o_stall,
  output logic [15:0] o_pend_mask,
  output logic        o_err
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  arb_state_e state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       stall_q, stall_d;
  logic       err_q, err_d;
  wb_pay_t    rf_q;

  logic       push, pop, grant, sel_aux, empty;
  aux_ent_t   push_ent, head;
  logic [1:0] count;
  logic [AUX_DEPTH-1:0] ent_vld;
  logic [3:0] ent_dir [AUX_DEPTH];

  assign o_aux_ready = rst_n && (count != 2'd2);
  assign push        = i_aux_valid && o_aux_ready;
  assign push_ent    = '{data: i_aux_data,
                         dir:  i_aux_dir};
  assign empty       = (count == 2'd0);

  aux_wb_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .ent_vld  (ent_vld),
    .ent_dir  (ent_dir)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    pop     = 1'b0;
    grant   = 1'b0;
    sel_aux = 1'b0;
    unique case (state_q)
      PIPE: begin
        if (i_WE_MEM_WB) begin
          grant = 1'b1;
          if (empty) begin
            wait_d = 8'd0;
          end else if (wait_q == WAIT_LAST) begin
            wait_d  = wait_q + 8'd1;
            state_d = DRAIN;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else begin
          wait_d = 8'd0;
          if (!empty) begin
            pop     = 1'b1;
            grant   = 1'b1;
            sel_aux = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Pipeline write in this cycle is dropped.
        pop     = !empty;
        grant   = !empty;
        sel_aux = 1'b1;
        wait_d  = 8'd0;
        state_d = PIPE;
        if (i_WE_MEM_WB) err_d = 1'b1;
      end
      default: state_d = PIPE;
    endcase
    stall_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PIPE;
      wait_q  <= 8'd0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      rf_q.we <= grant;
      if (grant) begin
        rf_q.data <= sel_aux ? head.data
                             : i_WB_Data;
        rf_q.dir  <= sel_aux ? head.dir
                             : i_WB_Dir;
      end
    end
  end

  always_comb begin
    o_pend_mask = '0;
    for (int i = 0; i < AUX_DEPTH; i++) begin
      if (ent_vld[i]) o_pend_mask[ent_dir[i]] = 1'b1;
    end
  end

  assign o_RF_WE   = rf_q.we;
  assign o_RF_Data = rf_q.data;
  assign o_RF_Dir  = rf_q.dir;
  assign o_stall   = stall_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (MAX_WAIT=8).
// Linear stimulus, immediate assertions at each check point.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_WE_MEM_WB;
  logic [31:0] i_WB_Data;
  logic [3:0]  i_WB_Dir;
  logic        i_aux_valid;
  logic [31:0] i_aux_data;
  logic [3:0]  i_aux_dir;
  logic        o_aux_ready;
  logic        o_RF_WE;
  logic [31:0] o_RF_Data;
  logic [3:0]  o_RF_Dir;
  logic        o_stall;
  logic [15:0] o_pend_mask;
  logic        o_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.MAX_WAIT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_WE_MEM_WB (i_WE_MEM_WB),
    .i_WB_Data   (i_WB_Data),
    .i_WB_Dir    (i_WB_Dir),
    .i_aux_valid (i_aux_valid),
    .i_aux_data  (i_aux_data),
    .i_aux_dir   (i_aux_dir),
    .o_aux_ready (o_aux_ready),
    .o_RF_WE     (o_RF_WE),
    .o_RF_Data   (o_RF_Data),
    .o_RF_Dir    (o_RF_Dir),
    .o_stall     (o_stall),
    .o_pend_mask (o_pend_mask),
    .o_err       (o_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we,
                      input logic [31:0] d,
                      input logic [3:0] r);
    i_WE_MEM_WB = we;
    i_WB_Data   = d;
    i_WB_Dir    = r;
  endtask

  task automatic aux(input logic v,
                     input logic [31:0] d,
                     input logic [3:0] r);
    i_aux_valid = v;
    i_aux_data  = d;
    i_aux_dir   = r;
  endtask

  initial begin
    rst_n = 1'b0;
    pipe(1'b0, 32'h0, 4'h0);
    aux(1'b0, 32'h0, 4'h0);
    step();
    step();
    chk("rst_ready", 32'(o_aux_ready), 32'h0);
    chk("rst_we", 32'(o_RF_WE), 32'h0);
    rst_n = 1'b1;
    step();
    chk("idle_we", 32'(o_RF_WE), 32'h0);
    chk("idle_stall", 32'(o_stall), 32'h0);
    chk("idle_ready", 32'(o_aux_ready), 32'h1);
    chk("idle_mask", 32'(o_pend_mask), 32'h0);
    chk("idle_err", 32'(o_err), 32'h0);

    // Pipeline write, then hold of data/dir.
    pipe(1'b1, 32'hDEADBEEF, 4'd5);
    step();
    chk("pw_we", 32'(o_RF_WE), 32'h1);
    chk("pw_data", o_RF_Data, 32'hDEADBEEF);
    chk("pw_dir", 32'(o_RF_Dir), 32'd5);
    pipe(1'b0, 32'h0, 4'd0);
    step();
    chk("hold_we", 32'(o_RF_WE), 32'h0);
    chk("hold_data", o_RF_Data, 32'hDEADBEEF);
    chk("hold_dir", 32'(o_RF_Dir), 32'd5);

    // Aux write in an idle slot.
    aux(1'b1, 32'h1234, 4'd3);
    step();
    aux(1'b0, 32'h0, 4'd0);
    chk("ia_mask", 32'(o_pend_mask), 32'h0008);
    chk("ia_we0", 32'(o_RF_WE), 32'h0);
    step();
    chk("ia_we", 32'(o_RF_WE), 32'h1);
    chk("ia_data", o_RF_Data, 32'h1234);
    chk("ia_dir", 32'(o_RF_Dir), 32'd3);
    chk("ia_mask0", 32'(o_pend_mask), 32'h0);

    // Fill the buffer while the pipeline writes.
    pipe(1'b1, 32'hA1, 4'd9);
    aux(1'b1, 32'h11, 4'd1);
    step();
    pipe(1'b1, 32'hA2, 4'd10);
    aux(1'b1, 32'h22, 4'd2);
    step();
    chk("full_ready", 32'(o_aux_ready), 32'h0);
    chk("full_mask", 32'(o_pend_mask), 32'h0006);
    chk("full_data", o_RF_Data, 32'hA2);
    pipe(1'b1, 32'hA3, 4'd11);
    aux(1'b1, 32'h77, 4'd7);
    step();
    chk("bp_mask", 32'(o_pend_mask), 32'h0006);
    chk("bp_ready", 32'(o_aux_ready), 32'h0);
    chk("bp_data", o_RF_Data, 32'hA3);
    pipe(1'b0, 32'h0, 4'd0);
    step();
    chk("pop1_data", o_RF_Data, 32'h11);
    chk("pop1_dir", 32'(o_RF_Dir), 32'd1);
    chk("pop1_mask", 32'(o_pend_mask), 32'h0004);
    chk("pop1_ready", 32'(o_aux_ready), 32'h1);
    step();
    aux(1'b0, 32'h0, 4'd0);
    chk("pp_data", o_RF_Data, 32'h22);
    chk("pp_mask", 32'(o_pend_mask), 32'h0080);
    step();
    chk("pop3_data", o_RF_Data, 32'h77);
    chk("pop3_dir", 32'(o_RF_Dir), 32'd7);
    chk("pop3_mask", 32'(o_pend_mask), 32'h0);

    // Starvation with a bubble in the drain cycle.
    pipe(1'b1, 32'hB0, 4'd12);
    aux(1'b1, 32'h44, 4'd4);
    step();
    aux(1'b0, 32'h0, 4'd0);
    for (int i = 0; i < 7; i++) step();
    chk("sv_stall7", 32'(o_stall), 32'h0);
    chk("sv_mask", 32'(o_pend_mask), 32'h0010);
    step();
    chk("sv_stall8", 32'(o_stall), 32'h1);
    chk("sv_pdata", o_RF_Data, 32'hB0);
    pipe(1'b0, 32'h0, 4'd0);
    step();
    chk("dr_we", 32'(o_RF_WE), 32'h1);
    chk("dr_data", o_RF_Data, 32'h44);
    chk("dr_dir", 32'(o_RF_Dir), 32'd4);
    chk("dr_stall", 32'(o_stall), 32'h0);
    chk("dr_err", 32'(o_err), 32'h0);
    chk("dr_mask", 32'(o_pend_mask), 32'h0);

    // Pipeline writes through the stall.
    pipe(1'b1, 32'hC0, 4'd13);
    aux(1'b1, 32'h66, 4'd6);
    step();
    aux(1'b0, 32'h0, 4'd0);
    for (int i = 0; i < 8; i++) step();
    chk("pv_stall", 32'(o_stall), 32'h1);
    step();
    chk("pv_err", 32'(o_err), 32'h1);
    chk("pv_data", o_RF_Data, 32'h66);
    chk("pv_dir", 32'(o_RF_Dir), 32'd6);
    chk("pv_stall0", 32'(o_stall), 32'h0);
    aux(1'b1, 32'h88, 4'd8);
    step();
    aux(1'b1, 32'h99, 4'd9);
    step();
    aux(1'b0, 32'h0, 4'd0);
    chk("pv_err_hold", 32'(o_err), 32'h1);
    chk("pv_mask", 32'(o_pend_mask), 32'h0300);
    chk("pv_ready", 32'(o_aux_ready), 32'h0);

    // Asynchronous reset mid-operation.
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mask", 32'(o_pend_mask), 32'h0);
    chk("ar_err", 32'(o_err), 32'h0);
    chk("ar_we", 32'(o_RF_WE), 32'h0);
    chk("ar_data", o_RF_Data, 32'h0);
    chk("ar_ready", 32'(o_aux_ready), 32'h0);
    pipe(1'b0, 32'h0, 4'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_ready", 32'(o_aux_ready), 32'h1);
    chk("post_mask", 32'(o_pend_mask), 32'h0);
    chk("post_err", 32'(o_err), 32'h0);
    chk("post_we", 32'(o_RF_WE), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
